expr_status_sched: RTL and testbench

//   Round-robin scheduler that shares one status-merge register between

---
 rtl/expr_status_sched.sv | 137 +++++++++++++
 tb/tb_expr_status_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_status_sched.sv
// Round-robin scheduler sharing one masked status-merge register between NREQ
// requesters; each grant runs LOAD -> HOLD -> ACK and pulses a single ack.
module expr_status_sched #(
   parameter int NREQ     = 4,
   parameter int DW       = 4,
   parameter int HOLD_CYC = 2,
   localparam int IW      = $clog2(NREQ),
   localparam int SW      = 1 + 2*IW + DW
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ*DW-1:0] req_sel,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic               busy,
   output logic [DW-1:0]      result,
   output logic [SW-1:0]      status
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   localparam int             CW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CW-1:0]  CNT_INIT  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [IW-1:0]  LAST_INIT = IW'(NREQ - 1);

   logic [1:0]      state_q,    state_d;
   logic [NREQ-1:0] gnt_q,      gnt_d;
   logic [NREQ-1:0] ack_q,      ack_d;
   logic [DW-1:0]   result_q,   result_d;
   logic [IW-1:0]   gnt_idx_q,  gnt_idx_d;
   logic [IW-1:0]   last_idx_q, last_idx_d;
   logic [CW-1:0]   cnt_q,      cnt_d;

   logic [IW-1:0]   win_idx_s;
   logic [DW-1:0]   data_s;
   logic [DW-1:0]   sel_s;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = {NREQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Winner search: walk from farthest to nearest after last_idx so the nearest set req wins
   always_comb begin
      logic [IW-1:0] cand_v;
      win_idx_s = last_idx_q;
      cand_v    = last_idx_q;
      for (int k = NREQ; k >= 1; k--) begin
         cand_v    = last_idx_q + IW'(k);
         win_idx_s = req[cand_v] ? cand_v : win_idx_s;
      end
   end

   assign data_s = req_data[gnt_idx_q*DW +: DW];
   assign sel_s  = req_sel[gnt_idx_q*DW +: DW];

   // Next-state logic for the grant/merge/hold/ack sequence
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack_d      = {NREQ{1'b0}};
      result_d   = result_q;
      gnt_idx_d  = gnt_idx_q;
      last_idx_d = last_idx_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d   = ST_LOAD;
               gnt_d     = onehot(win_idx_s);
               gnt_idx_d = win_idx_s;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_LOAD: begin
            result_d = (sel_s & data_s) | (~sel_s & result_q);
            cnt_d    = CNT_INIT;
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            // ack is registered so it lines up exactly with the ACK state
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_ACK;
               ack_d   = onehot(gnt_idx_q);
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         ST_ACK: begin
            last_idx_d = gnt_idx_q;
            gnt_d      = {NREQ{1'b0}};
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = {NREQ{1'b0}};
         end
      endcase
   end

   // State registers; reset abandons any in-flight operation without an ack
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         gnt_q      <= {NREQ{1'b0}};
         ack_q      <= {NREQ{1'b0}};
         result_q   <= {DW{1'b0}};
         gnt_idx_q  <= {IW{1'b0}};
         last_idx_q <= LAST_INIT;
         cnt_q      <= {CW{1'b0}};
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         result_q   <= result_d;
         gnt_idx_q  <= gnt_idx_d;
         last_idx_q <= last_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign gnt    = gnt_q;
   assign ack    = ack_q;
   assign busy   = (state_q != ST_IDLE);
   assign result = result_q;
   assign status = {busy, gnt_idx_q, last_idx_q, result_q};

endmodule

// File: tb/tb_expr_status_sched.sv
// Bench for expr_status_sched: directed literal checks plus randomized traffic
// compared every cycle against an operation-age reference model.
module tb_expr_status_sched;

   localparam int NREQ = 4;
   localparam int DW   = 4;
   localparam int HOLD = 2;
   localparam int IW   = 2;
   localparam int SW   = 9;

   logic               sysclk;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ*DW-1:0] req_sel;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic               busy;
   logic [DW-1:0]      result;
   logic [SW-1:0]      status;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model: operation age counted in edges since the grant edge
   bit            m_busy;
   int            m_age;
   int            m_gidx;
   int            m_last;
   logic [DW-1:0] m_res;

   expr_status_sched #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(HOLD)) dut (
      .sysclk  (sysclk),
      .reset   (reset),
      .req     (req),
      .req_data(req_data),
      .req_sel (req_sel),
      .gnt     (gnt),
      .ack     (ack),
      .busy    (busy),
      .result  (result),
      .status  (status)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_age  = 0;
      m_gidx = 0;
      m_last = NREQ - 1;
      m_res  = '0;
   endtask

   task automatic model_step();
      int w;
      logic [DW-1:0] d, s;
      if (reset) begin
         if (!m_busy) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               int i;
               i = (m_last + k) % NREQ;
               if (w < 0 && req[i]) w = i;
            end
            if (w >= 0) begin
               m_busy = 1'b1;
               m_gidx = w;
               m_age  = 0;
            end
         end else begin
            m_age++;
            if (m_age == 1) begin
               d = req_data[m_gidx*DW +: DW];
               s = req_sel[m_gidx*DW +: DW];
               m_res = (s & d) | (~s & m_res);
            end
            if (m_age == HOLD + 2) begin
               m_last = m_gidx;
               m_busy = 1'b0;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge sysclk);
         model_step();
      end
   end

   // single compare process against the model, away from the active edge
   initial begin
      forever begin
         logic [NREQ-1:0] e_gnt, e_ack;
         logic [SW-1:0]   e_st;
         logic [IW-1:0]   gi, li;
         @(negedge sysclk);
         if (chk_en) begin
            e_gnt = m_busy ? (NREQ'(1) << m_gidx) : '0;
            e_ack = (m_busy && m_age == HOLD + 1) ? (NREQ'(1) << m_gidx) : '0;
            gi    = IW'(m_gidx);
            li    = IW'(m_last);
            e_st  = {m_busy, gi, li, m_res};
            chk("model_gnt",    32'(gnt),    32'(e_gnt));
            chk("model_ack",    32'(ack),    32'(e_ack));
            chk("model_busy",   32'(busy),   32'(m_busy));
            chk("model_result", 32'(result), 32'(m_res));
            chk("model_status", 32'(status), 32'(e_st));
         end
      end
   end

   task automatic cyc();
      @(posedge sysclk);
      @(negedge sysclk);
   endtask

   task automatic pulse_reset();
      @(posedge sysclk);
      #2;
      reset = 1'b0;
      model_reset();
      @(negedge sysclk);
      @(posedge sysclk);
      #2;
      reset = 1'b1;
      @(negedge sysclk);
   endtask

   initial begin
      logic [IW-1:0] last_v;
      int p, g;
      reset    = 1'b0;
      req      = '0;
      req_data = '0;
      req_sel  = '0;
      model_reset();
      @(negedge sysclk);
      chk_en = 1'b1;
      chk("rst_status", 32'(status), 32'(9'b0_00_11_0000));
      chk("rst_gnt",    32'(gnt),    32'(4'b0000));
      chk("rst_ack",    32'(ack),    32'(4'b0000));
      chk("rst_busy",   32'(busy),   32'(1'b0));
      reset = 1'b1;
      cyc();

      // single request from requester 2
      req = 4'b0100; req_data = 16'h0A00; req_sel = 16'h0F00;
      cyc(); cyc();
      chk("single_hold_status", 32'(status), 32'(9'b1_10_11_1010));
      chk("single_gnt",         32'(gnt),    32'(4'b0100));
      req = 4'b0000;
      cyc();
      chk("single_no_early_ack", 32'(ack), 32'(4'b0000));
      cyc();
      chk("single_ack", 32'(ack), 32'(4'b0100));
      cyc();
      chk("single_ack_one_cycle", 32'(ack),    32'(4'b0000));
      chk("single_idle_status",   32'(status), 32'(9'b0_10_10_1010));

      // masked merge: 0xA merged with data 0x5 under sel 0011
      req = 4'b0010; req_data = 16'h0050; req_sel = 16'h0030;
      cyc(); cyc();
      chk("masked_merge", 32'(result), 32'(4'h9));
      req = 4'b0000;
      cyc(); cyc(); cyc();

      // reset in the middle of HOLD
      req = 4'b1000;
      cyc(); cyc();
      chk("pre_reset_gnt", 32'(gnt), 32'(4'b1000));
      req = 4'b0000;
      @(posedge sysclk);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("midrst_busy",   32'(busy),   32'(1'b0));
      chk("midrst_gnt",    32'(gnt),    32'(4'b0000));
      chk("midrst_ack",    32'(ack),    32'(4'b0000));
      chk("midrst_result", 32'(result), 32'(4'h0));
      chk("midrst_status", 32'(status), 32'(9'b0_00_11_0000));
      @(negedge sysclk);
      @(posedge sysclk);
      #2;
      reset = 1'b1;
      @(negedge sysclk);
      cyc(); cyc();
      req = 4'b1001;
      cyc();
      chk("post_rst_first_gnt", 32'(gnt), 32'(4'b0001));
      req = 4'b0000;
      cyc(); cyc(); cyc(); cyc();

      // all requesting from a fresh reset: rotation 0,1,2,3,0 with period 5
      pulse_reset();
      req = 4'b1111;
      for (int c = 1; c <= 25; c++) begin
         cyc();
         p = (c - 1) % 5;
         g = ((c - 1) / 5) % 4;
         chk("all_ack", 32'(ack), (p == 3) ? (32'd1 << g) : 32'd0);
         if (p == 0) chk("all_gnt", 32'(gnt), 32'd1 << g);
      end

      // early release by requester 3 during LOAD
      req = 4'b1000;
      cyc();
      chk("early_gnt", 32'(gnt), 32'(4'b1000));
      req = 4'b0000;
      cyc(); cyc(); cyc();
      chk("early_ack", 32'(ack), 32'(4'b1000));
      cyc();
      last_v = status[DW +: IW];
      chk("early_last_idx", 32'(last_v), 32'(2'd3));

      // sole requester held continuously
      req = 4'b0010;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         p = (c - 1) % 5;
         chk("sole_ack", 32'(ack), (p == 3) ? 32'(4'b0010) : 32'd0);
         chk("sole_gnt_bit", 32'(gnt & 4'b1101), 32'd0);
      end
      req = 4'b0000;
      cyc();

      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         req      = NREQ'($urandom_range(0, 15));
         req_data = 16'($urandom);
         req_sel  = 16'($urandom);
         if ($urandom_range(0, 149) == 0) pulse_reset();
         else cyc();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
